// File: rtl/seq_divider_if.sv
// Request/result handshake bundle for the iterative divider.
// slave = divider side, master = requester/consumer side.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport slave (
    input  in_valid,
    input  in_signed,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output div_by_zero
  );

  modport master (
    output in_valid,
    output in_signed,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock.
// Signed mode divides magnitudes and fixes signs on exit.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] num_nx, rem_nx;
  logic             neg_a, neg_b, ovf;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    neg_a = bus.in_signed & bus.dividend[WIDTH-1];
    neg_b = bus.in_signed & bus.divisor[WIDTH-1];
    mag_a = neg_a ? -bus.dividend : bus.dividend;
    mag_b = neg_b ? -bus.divisor : bus.divisor;
    ovf   = bus.in_signed
          && (bus.dividend == MIN)
          && (bus.divisor == '1);
    // Partial remainder is W+1 bits wide after the shift-in.
    sh     = {rem_q, num_q[WIDTH-1]};
    ge     = sh >= {1'b0, dvs_q};
    diff   = sh[WIDTH-1:0] - dvs_q;
    rem_nx = ge ? diff : sh[WIDTH-1:0];
    num_nx = {num_q[WIDTH-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          num_d  = mag_a;
          dvs_d  = mag_b;
          rem_d  = '0;
          cnt_d  = '0;
          qneg_d = neg_a ^ neg_b;
          rneg_d = neg_a;
          if (bus.divisor == '0) begin
            quo_d   = '1;
            res_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else if (ovf) begin
            quo_d   = MIN;
            res_d   = '0;
            dbz_d   = 1'b0;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        num_d = num_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          quo_d   = qneg_q ? -num_nx : num_nx;
          res_d   = rneg_q ? -rem_nx : rem_nx;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      num_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = res_q;
  assign bus.div_by_zero = dbz_q;
endmodule
